// File: rtl/hazard_ctrl_unit_pkg.sv
// hazard_pkg: shared definitions for the hazard control unit.
//   FWD_*      : forwarding mux select encodings driven onto fwd*_* outputs
//   md_state_t : state of the mult/div busy tracker
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;  // register file / value already in the pipe
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// md_busy_tracker: tracks occupancy of the multiply/divide unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   md_start     : EX instruction starts an MD op this cycle
//   md_is_div    : qualifies md_start, selects divide latency
//   md_cancel    : flush, aborts any MD op (wins over a simultaneous start)
//   md_busy      : high for exactly MUL_LAT/DIV_LAT cycles, starting the cycle after the start
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_is_div,
  input  logic md_cancel,
  output logic md_busy
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (md_cancel) begin
      state_next = MD_IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        MD_IDLE: begin
          if (md_start) begin
            state_next = MD_BUSY;
            // Counter holds remaining busy cycles after the current one.
            cnt_next   = md_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          end
        end
        MD_BUSY: begin
          // A start while busy cannot reach EX because the MD stall holds it in ID.
          if (cnt_reg == '0) state_next = MD_IDLE;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign md_busy = (state_reg == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding selects, Tuse/Tnew stall detection and
// mult/div busy stall for the 5-stage pipeline.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a1_id/a2_id, tuse1/2_id    : ID sources and cycles until each is consumed
//   a1_ex/a2_ex                : EX sources
//   a2_mem                     : MEM store-data source
//   a3_ex/mem/wb, tnew_ex/mem/wb : destinations (0 = none) and cycles until result exists
//   md_use_id, md_start_ex, md_is_div, md_cancel : MD unit control
//   fwd1/2_id, fwd1/2_ex       : 0=RF 1=EX 2=MEM 3=WB
//   fwd2_mem                   : 0=pipe value 3=WB
//   stall                      : hold PC and IF/ID, bubble ID/EX
//   md_busy                    : MD unit occupied
//   stall_cnt                  : saturating count of stall cycles
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a1_id,
  input  logic [AW-1:0]    a2_id,
  input  logic [TW-1:0]    tuse1_id,
  input  logic [TW-1:0]    tuse2_id,
  input  logic [AW-1:0]    a1_ex,
  input  logic [AW-1:0]    a2_ex,
  input  logic [AW-1:0]    a2_mem,
  input  logic [AW-1:0]    a3_ex,
  input  logic [AW-1:0]    a3_mem,
  input  logic [AW-1:0]    a3_wb,
  input  logic [TW-1:0]    tnew_ex,
  input  logic [TW-1:0]    tnew_mem,
  input  logic [TW-1:0]    tnew_wb,
  input  logic             md_use_id,
  input  logic             md_start_ex,
  input  logic             md_is_div,
  input  logic             md_cancel,
  output logic [1:0]       fwd1_id,
  output logic [1:0]       fwd2_id,
  output logic [1:0]       fwd1_ex,
  output logic [1:0]       fwd2_ex,
  output logic [1:0]       fwd2_mem,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Nearest enabled matching stage wins. If that stage's result is not ready
  // yet, select RF and never fall through to an older stage's stale value.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] addr,
    input logic          en_e,
    input logic [AW-1:0] a3_e,
    input logic [TW-1:0] t_e,
    input logic          en_m,
    input logic [AW-1:0] a3_m,
    input logic [TW-1:0] t_m,
    input logic          en_w,
    input logic [AW-1:0] a3_w,
    input logic [TW-1:0] t_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (addr != '0) begin
      if (en_e && addr == a3_e)      sel = (t_e == '0) ? FWD_EX  : FWD_RF;
      else if (en_m && addr == a3_m) sel = (t_m == '0) ? FWD_MEM : FWD_RF;
      else if (en_w && addr == a3_w) sel = (t_w == '0) ? FWD_WB  : FWD_RF;
    end
    return sel;
  endfunction

  logic [AW-1:0] a_id      [2];
  logic [TW-1:0] tuse_id   [2];
  logic [1:0]    fwd_id    [2];
  logic          stall_op  [2];
  logic          data_stall;
  logic          md_stall;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign a_id[0]    = a1_id;
  assign a_id[1]    = a2_id;
  assign tuse_id[0] = tuse1_id;
  assign tuse_id[1] = tuse2_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_id_op
      assign fwd_id[gi] = fwd_sel(a_id[gi], 1'b1, a3_ex, tnew_ex,
                                  1'b1, a3_mem, tnew_mem, 1'b1, a3_wb, tnew_wb);
      // WB results are always ready by ID's consume point, so only EX/MEM stall.
      assign stall_op[gi] = (a_id[gi] != '0) &&
                            (((a_id[gi] == a3_ex)  && (tnew_ex  > tuse_id[gi])) ||
                             ((a_id[gi] == a3_mem) && (tnew_mem > tuse_id[gi])));
    end
  endgenerate

  assign fwd1_id  = fwd_id[0];
  assign fwd2_id  = fwd_id[1];
  assign fwd1_ex  = fwd_sel(a1_ex, 1'b0, a3_ex, tnew_ex,
                            1'b1, a3_mem, tnew_mem, 1'b1, a3_wb, tnew_wb);
  assign fwd2_ex  = fwd_sel(a2_ex, 1'b0, a3_ex, tnew_ex,
                            1'b1, a3_mem, tnew_mem, 1'b1, a3_wb, tnew_wb);
  assign fwd2_mem = fwd_sel(a2_mem, 1'b0, a3_ex, tnew_ex,
                            1'b0, a3_mem, tnew_mem, 1'b1, a3_wb, tnew_wb);

  assign data_stall = stall_op[0] || stall_op[1];
  // A start in EX this cycle already occupies the unit for the ID instruction.
  assign md_stall   = md_use_id && (md_busy || md_start_ex);
  assign stall      = data_stall || md_stall;

  md_busy_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start_ex),
    .md_is_div (md_is_div),
    .md_cancel (md_cancel),
    .md_busy   (md_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_cnt_reg <= '0;
    else if (stall && (stall_cnt_reg != '1))     stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] a1_id, a2_id, a1_ex, a2_ex, a2_mem, a3_ex, a3_mem, a3_wb;
  logic [1:0] tuse1_id, tuse2_id, tnew_ex, tnew_mem, tnew_wb;
  logic       md_use_id, md_start_ex, md_is_div, md_cancel;
  logic [1:0] fwd1_id, fwd2_id, fwd1_ex, fwd2_ex, fwd2_mem;
  logic       stall, md_busy;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .AW(5), .TW(2), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a1_id(a1_id), .a2_id(a2_id), .tuse1_id(tuse1_id), .tuse2_id(tuse2_id),
    .a1_ex(a1_ex), .a2_ex(a2_ex), .a2_mem(a2_mem),
    .a3_ex(a3_ex), .a3_mem(a3_mem), .a3_wb(a3_wb),
    .tnew_ex(tnew_ex), .tnew_mem(tnew_mem), .tnew_wb(tnew_wb),
    .md_use_id(md_use_id), .md_start_ex(md_start_ex),
    .md_is_div(md_is_div), .md_cancel(md_cancel),
    .fwd1_id(fwd1_id), .fwd2_id(fwd2_id), .fwd1_ex(fwd1_ex), .fwd2_ex(fwd2_ex),
    .fwd2_mem(fwd2_mem), .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    a1_id = 0; a2_id = 0; a1_ex = 0; a2_ex = 0; a2_mem = 0;
    a3_ex = 0; a3_mem = 0; a3_wb = 0;
    tuse1_id = 0; tuse2_id = 0; tnew_ex = 0; tnew_mem = 0; tnew_wb = 0;
    md_use_id = 0; md_start_ex = 0; md_is_div = 0; md_cancel = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- forwarding, combinational ----
    a1_id = 8; a3_ex = 8; tnew_ex = 0; #1;
    chk("fwd1_id_ex", fwd1_id, 1);
    chk("stall_ex_ready", stall, 0);
    a3_mem = 8; tnew_mem = 0; #1;
    chk("fwd1_id_ex_over_mem", fwd1_id, 1);
    a3_ex = 0; a3_mem = 0; a3_wb = 8; #1;
    chk("fwd1_id_wb", fwd1_id, 3);
    // nearest match not ready: no fall-through to MEM
    a3_ex = 8; tnew_ex = 1; a3_mem = 8; tnew_mem = 0; tuse1_id = 1; #1;
    chk("fwd1_id_nofall", fwd1_id, 0);
    chk("stall_tnew_eq_tuse", stall, 0);
    clr(); a2_id = 9; a3_mem = 9; tnew_mem = 1; tuse2_id = 0; #1;
    chk("stall_mem", stall, 1);
    chk("fwd2_id_mem_notready", fwd2_id, 0);
    clr(); a2_ex = 0; a3_mem = 0; tnew_mem = 0; #1;
    chk("fwd2_ex_r0", fwd2_ex, 0);
    a2_ex = 6; a1_ex = 6; a3_mem = 6; a3_wb = 6; #1;
    chk("fwd2_ex_mem", fwd2_ex, 2);
    chk("fwd1_ex_mem", fwd1_ex, 2);
    a2_mem = 5; a3_wb = 5; tnew_wb = 0; #1;
    chk("fwd2_mem_wb", fwd2_mem, 3);
    chk("fwd1_ex_mem_only", fwd1_ex, 2);
    tnew_wb = 1; #1;
    chk("fwd2_mem_notready", fwd2_mem, 0);

    // ---- data stall and stall counter ----
    clr(); step();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    a1_id = 8; tuse1_id = 0; a3_ex = 8; tnew_ex = 2; #1;
    chk("stall_ex", stall, 1);
    chk("cnt0", stall_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("cnt%0d", i), stall_cnt, i);
    end
    for (int i = 0; i < 12; i++) step();
    chk("cnt_full", stall_cnt, 15);
    for (int i = 0; i < 3; i++) step();
    chk("cnt_sat", stall_cnt, 15);
    tuse1_id = 2; #1;
    chk("stall_tuse2", stall, 0);
    chk("fwd1_id_tuse2", fwd1_id, 0);
    step();
    chk("cnt_hold", stall_cnt, 15);

    // ---- divide: busy exactly 10 cycles, stall throughout ----
    clr(); md_use_id = 1; md_start_ex = 1; md_is_div = 1; #1;
    chk("md_stall_start", stall, 1);
    chk("md_busy_pre", md_busy, 0);
    step();
    md_start_ex = 0; md_is_div = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("div_busy_c%0d", i), md_busy, (i < 10) ? 1 : 0);
      chk($sformatf("div_stall_c%0d", i), stall, (i < 10) ? 1 : 0);
      step();
    end

    // ---- multiply: busy exactly 5 cycles ----
    clr(); md_start_ex = 1; step(); md_start_ex = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mul_busy_c%0d", i), md_busy, (i < 5) ? 1 : 0);
      step();
    end

    // ---- cancel with simultaneous start ----
    clr(); md_start_ex = 1; md_is_div = 1; md_cancel = 1; step();
    clr();
    chk("cancel_start", md_busy, 0);
    step();
    chk("cancel_start_2", md_busy, 0);

    // ---- cancel at busy cycle 4 ----
    md_start_ex = 1; md_is_div = 1; step(); clr();
    for (int i = 1; i < 4; i++) step();
    chk("busy_c4", md_busy, 1);
    md_cancel = 1; step(); md_cancel = 0;
    chk("cancel_c4", md_busy, 0);

    // ---- async reset mid-division ----
    clr(); md_use_id = 1; md_start_ex = 1; md_is_div = 1; step();
    md_start_ex = 0; md_is_div = 0;
    step(); step();
    chk("mid_div_busy", md_busy, 1);
    #2; rst_n = 1'b0; #1;
    chk("async_rst_busy", md_busy, 0);
    chk("async_rst_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", md_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
